synaptic_update_sequencer: RTL and testbench

Training-phase controller directly upstream of synaptic_core. On a START request it sweeps every synaptic word once, issuing a read-then-write pair on the synaptic and gradient arrays so ffstdp_update writes back new weights and gradients. It also drives pre- and post-neuron memory reads so that PRE_NEUR_S_CNT and POST_NEUR_S_CNT are valid during each write cycle.

---
 rtl/snn_ff_syn_pkg.sv | 26 ++
 rtl/synaptic_update_sequencer_if.sv | 33 +++
 rtl/syn_addr_gen.sv | 64 ++++++
 rtl/synaptic_update_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_synaptic_update_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_ff_syn_pkg.sv
// Shared types and sizing helpers for the synaptic update sequencer.
// Holds the sweep state encoding and the words-per-pre-neuron calculation.
// Default sizing constants match the production network (784 x 256, 4 per word).
package snn_ff_syn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FETCH,
        PRE_CHK,
        SYN_RD,
        SYN_WR,
        FIN
    } state_t;

    localparam int DEF_INPUT_NEURON       = 784;
    localparam int DEF_OUTPUT_NEURON      = 256;
    localparam int DEF_POST_NEUR_PARALLEL = 4;

    // Synaptic words per pre neuron: post neurons are packed POST_NEUR_PARALLEL per word.
    function automatic int words_per_pre(input int output_neuron, input int post_neur_parallel);
        return output_neuron / post_neur_parallel;
    endfunction

    localparam int WPP = words_per_pre(DEF_OUTPUT_NEURON, DEF_POST_NEUR_PARALLEL);

endpackage

// File: rtl/synaptic_update_sequencer_if.sv
// Memory-side bus of the sequencer: pre/post neuron read ports and the
// synaptic/gradient array strobes. master = sequencer, slave = memories.
interface synaptic_update_sequencer_if #(
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16,
    parameter int PRE_NEUR_DATA_WIDTH  = 8
);
    logic [PRE_NEUR_DATA_WIDTH-1:0]  PRE_NEUR_S_CNT;
    logic                            PRE_NEUR_CS;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  PRE_NEUR_ADDR;
    logic                            POST_NEUR_CS;
    logic [POST_NEUR_ADDR_WIDTH-1:0] POST_NEUR_ADDR;
    logic                            CTRL_SYNARRAY_CS;
    logic                            CTRL_SYNARRAY_WE;
    logic                            CTRL_GRAD_ARRAY_CS;
    logic                            CTRL_GRAD_ARRAY_WE;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR;

    modport master (
        input  PRE_NEUR_S_CNT,
        output PRE_NEUR_CS, PRE_NEUR_ADDR, POST_NEUR_CS, POST_NEUR_ADDR,
        output CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_GRAD_ARRAY_CS, CTRL_GRAD_ARRAY_WE,
        output CTRL_SYNARRAY_ADDR
    );

    modport slave (
        output PRE_NEUR_S_CNT,
        input  PRE_NEUR_CS, PRE_NEUR_ADDR, POST_NEUR_CS, POST_NEUR_ADDR,
        input  CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_GRAD_ARRAY_CS, CTRL_GRAD_ARRAY_WE,
        input  CTRL_SYNARRAY_ADDR
    );
endinterface

// File: rtl/syn_addr_gen.sv
// Purpose: pre/word sweep counters and registered synaptic/post address generation.
// Latency: addresses are registered from the next counter values, aligned with the counters.
// Backpressure: none internally; counters only move on explicit clear/increment commands.
module syn_addr_gen #(
    parameter int INPUT_NEURON         = 784,
    parameter int WORDS                = 64,
    parameter int POST_NEUR_PARALLEL   = 4,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            word_inc,
    input  logic                            pre_inc,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_idx,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] post_addr,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] syn_addr,
    output logic                            last_word,
    output logic                            last_pre
);
    localparam logic [PRE_NEUR_ADDR_WIDTH-1:0]  LAST_PRE  = PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
    localparam logic [POST_NEUR_ADDR_WIDTH-1:0] LAST_WORD = POST_NEUR_ADDR_WIDTH'(WORDS - 1);

    logic [POST_NEUR_ADDR_WIDTH-1:0] word_idx;
    logic [POST_NEUR_ADDR_WIDTH-1:0] word_nxt;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_nxt;

    // Next counter values: advancing the pre neuron restarts the word sweep at 0.
    always_comb begin
        pre_nxt  = pre_idx;
        word_nxt = word_idx;
        if (clr) begin
            pre_nxt  = '0;
            word_nxt = '0;
        end else if (pre_inc) begin
            pre_nxt  = pre_idx + PRE_NEUR_ADDR_WIDTH'(1);
            word_nxt = '0;
        end else if (word_inc) begin
            word_nxt = word_idx + POST_NEUR_ADDR_WIDTH'(1);
        end
    end

    // Counters plus the multiply-add address, registered together so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_idx   <= '0;
            word_idx  <= '0;
            syn_addr  <= '0;
            post_addr <= '0;
        end else begin
            pre_idx   <= pre_nxt;
            word_idx  <= word_nxt;
            syn_addr  <= SYN_ARRAY_ADDR_WIDTH'(pre_nxt) * SYN_ARRAY_ADDR_WIDTH'(WORDS)
                       + SYN_ARRAY_ADDR_WIDTH'(word_nxt);
            post_addr <= word_nxt * POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
        end
    end

    assign last_word = (word_idx == LAST_WORD);
    assign last_pre  = (pre_idx == LAST_PRE);

endmodule

// File: rtl/synaptic_update_sequencer.sv
// Purpose: training sweep controller issuing RD/WR pairs on synaptic+gradient arrays per word; optional SYN_UPD_SKIP_ZERO_PRE_EN skips pre neurons with zero spike count.
// Latency: all outputs registered; no-stall sweep is INPUT_NEURON*(2+2*WPP)+1 cycles from START to DONE.
// Backpressure: STALL holds entry into PRE_FETCH/SYN_RD with every strobe low; an RD/WR pair is never split.
module synaptic_update_sequencer
    import snn_ff_syn_pkg::*;
#(
    parameter int INPUT_NEURON         = DEF_INPUT_NEURON,
    parameter int OUTPUT_NEURON        = DEF_OUTPUT_NEURON,
    parameter int POST_NEUR_PARALLEL   = DEF_POST_NEUR_PARALLEL,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16,
    parameter int PRE_NEUR_DATA_WIDTH  = 8
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic START,
    input  logic STALL,
    output logic BUSY,
    output logic DONE,
    synaptic_update_sequencer_if.master mem
);
    localparam int WORDS = words_per_pre(OUTPUT_NEURON, POST_NEUR_PARALLEL);

    // Sizing must leave no partial word and no counter overflow.
    if ((OUTPUT_NEURON % POST_NEUR_PARALLEL) != 0) begin : g_wpp_chk
        $error("OUTPUT_NEURON must be a multiple of POST_NEUR_PARALLEL");
    end
    if (INPUT_NEURON > (1 << PRE_NEUR_ADDR_WIDTH)) begin : g_pre_chk
        $error("INPUT_NEURON does not fit PRE_NEUR_ADDR_WIDTH");
    end
    if (OUTPUT_NEURON > (1 << POST_NEUR_ADDR_WIDTH)) begin : g_post_chk
        $error("OUTPUT_NEURON does not fit POST_NEUR_ADDR_WIDTH");
    end
    if (INPUT_NEURON * WORDS > (1 << SYN_ARRAY_ADDR_WIDTH)) begin : g_syn_chk
        $error("synaptic array does not fit SYN_ARRAY_ADDR_WIDTH");
    end

    state_t state;
    state_t nxt_state;
    logic   hold;
    logic   nxt_hold;
    logic   clr_cnt;
    logic   word_inc;
    logic   pre_inc;
    logic   last_word;
    logic   last_pre;
    logic   zero_pre;
    logic   pre_cs_q;
    logic   post_cs_q;
    logic   syn_cs_q;
    logic   syn_we_q;

    logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_idx;
    logic [POST_NEUR_ADDR_WIDTH-1:0] post_addr;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] syn_addr;

`ifdef SYN_UPD_SKIP_ZERO_PRE_EN
    // A zero pre count yields zero deltas, so the whole row of words can be skipped.
    assign zero_pre = (mem.PRE_NEUR_S_CNT == '0);
`else
    logic unused_s_cnt;
    assign unused_s_cnt = ^mem.PRE_NEUR_S_CNT;
    assign zero_pre     = 1'b0;
`endif

    syn_addr_gen #(
        .INPUT_NEURON         (INPUT_NEURON),
        .WORDS                (WORDS),
        .POST_NEUR_PARALLEL   (POST_NEUR_PARALLEL),
        .PRE_NEUR_ADDR_WIDTH  (PRE_NEUR_ADDR_WIDTH),
        .POST_NEUR_ADDR_WIDTH (POST_NEUR_ADDR_WIDTH),
        .SYN_ARRAY_ADDR_WIDTH (SYN_ARRAY_ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (CLK),
        .rst_n     (RSTN),
        .clr       (clr_cnt),
        .word_inc  (word_inc),
        .pre_inc   (pre_inc),
        .pre_idx   (pre_idx),
        .post_addr (post_addr),
        .syn_addr  (syn_addr),
        .last_word (last_word),
        .last_pre  (last_pre)
    );

    // Next state and counter commands; hold marks a PRE_FETCH/SYN_RD cycle frozen by STALL.
    always_comb begin
        nxt_state = state;
        nxt_hold  = 1'b0;
        clr_cnt   = 1'b0;
        word_inc  = 1'b0;
        pre_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    nxt_state = PRE_FETCH;
                    nxt_hold  = STALL;
                    clr_cnt   = 1'b1;
                end
            end
            PRE_FETCH: begin
                if (hold) begin
                    nxt_hold = STALL;
                end else begin
                    nxt_state = PRE_CHK;
                end
            end
            PRE_CHK: begin
                if (zero_pre) begin
                    if (last_pre) begin
                        nxt_state = FIN;
                    end else begin
                        nxt_state = PRE_FETCH;
                        nxt_hold  = STALL;
                        pre_inc   = 1'b1;
                    end
                end else begin
                    nxt_state = SYN_RD;
                    nxt_hold  = STALL;
                end
            end
            SYN_RD: begin
                if (hold) begin
                    nxt_hold = STALL;
                end else begin
                    nxt_state = SYN_WR;
                end
            end
            SYN_WR: begin
                if (!last_word) begin
                    nxt_state = SYN_RD;
                    nxt_hold  = STALL;
                    word_inc  = 1'b1;
                end else if (!last_pre) begin
                    nxt_state = PRE_FETCH;
                    nxt_hold  = STALL;
                    pre_inc   = 1'b1;
                end else begin
                    nxt_state = FIN;
                end
            end
            FIN: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // State register with strobes registered from the next state, so every output is a flop.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            hold      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            pre_cs_q  <= 1'b0;
            post_cs_q <= 1'b0;
            syn_cs_q  <= 1'b0;
            syn_we_q  <= 1'b0;
        end else begin
            state     <= nxt_state;
            hold      <= nxt_hold;
            BUSY      <= (nxt_state != IDLE);
            DONE      <= (nxt_state == FIN);
            pre_cs_q  <= (nxt_state == PRE_FETCH) && !nxt_hold;
            post_cs_q <= (nxt_state == SYN_RD) && !nxt_hold;
            syn_cs_q  <= ((nxt_state == SYN_RD) && !nxt_hold) || (nxt_state == SYN_WR);
            syn_we_q  <= (nxt_state == SYN_WR);
        end
    end

    assign mem.PRE_NEUR_CS        = pre_cs_q;
    assign mem.PRE_NEUR_ADDR      = pre_idx;
    assign mem.POST_NEUR_CS       = post_cs_q;
    assign mem.POST_NEUR_ADDR     = post_addr;
    assign mem.CTRL_SYNARRAY_CS   = syn_cs_q;
    assign mem.CTRL_SYNARRAY_WE   = syn_we_q;
    assign mem.CTRL_GRAD_ARRAY_CS = syn_cs_q;
    assign mem.CTRL_GRAD_ARRAY_WE = syn_we_q;
    assign mem.CTRL_SYNARRAY_ADDR = syn_addr;

endmodule

// File: tb/tb_synaptic_update_sequencer.sv
// Bench for synaptic_update_sequencer with a 4 x 8 network (2 words per pre neuron).
// A toy SRAM adds 1 to each word on every RD/WR pair; expectations come from a step-list model.
// Honours SYN_UPD_SKIP_ZERO_PRE_EN when the design is built with it.
module tb_synaptic_update_sequencer;

    localparam int NPRE = 4;
    localparam int NOUT = 8;
    localparam int PAR  = 4;
    localparam int WPP  = NOUT / PAR;
    localparam int NW   = NPRE * WPP;
    localparam int NCYC = 96;
`ifdef SYN_UPD_SKIP_ZERO_PRE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RSTN = 1'b1;
    logic START = 1'b0;
    logic STALL = 1'b0;
    logic BUSY;
    logic DONE;

    int checks = 0;
    int errors = 0;

    synaptic_update_sequencer_if #(
        .PRE_NEUR_ADDR_WIDTH(10), .POST_NEUR_ADDR_WIDTH(10),
        .SYN_ARRAY_ADDR_WIDTH(16), .PRE_NEUR_DATA_WIDTH(8)
    ) m ();

    synaptic_update_sequencer #(
        .INPUT_NEURON(NPRE), .OUTPUT_NEURON(NOUT), .POST_NEUR_PARALLEL(PAR),
        .PRE_NEUR_ADDR_WIDTH(10), .POST_NEUR_ADDR_WIDTH(10),
        .SYN_ARRAY_ADDR_WIDTH(16), .PRE_NEUR_DATA_WIDTH(8)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .STALL(STALL),
        .BUSY(BUSY), .DONE(DONE), .mem(m)
    );

    always #5 CLK = ~CLK;

    // ---------------- memory models ----------------
    logic [7:0] pre_cnt [NPRE];
    logic [7:0] syn_mem [NW];
    logic [7:0] grad_mem [NW];
    logic [7:0] exp_syn [NW];
    logic [7:0] exp_grad [NW];
    logic [7:0] s_cnt_q = 8'd0;
    logic [7:0] syn_rd_q = 8'd0;
    logic [7:0] grad_rd_q = 8'd0;

    assign m.PRE_NEUR_S_CNT = s_cnt_q;

    always @(posedge CLK) begin
        if (m.PRE_NEUR_CS) s_cnt_q <= pre_cnt[m.PRE_NEUR_ADDR[1:0]];
        if (m.CTRL_SYNARRAY_CS) begin
            if (m.CTRL_SYNARRAY_WE) syn_mem[m.CTRL_SYNARRAY_ADDR[2:0]] <= syn_rd_q + 8'd1;
            else                    syn_rd_q <= syn_mem[m.CTRL_SYNARRAY_ADDR[2:0]];
        end
        if (m.CTRL_GRAD_ARRAY_CS) begin
            if (m.CTRL_GRAD_ARRAY_WE) grad_mem[m.CTRL_SYNARRAY_ADDR[2:0]] <= grad_rd_q + 8'd1;
            else                      grad_rd_q <= grad_mem[m.CTRL_SYNARRAY_ADDR[2:0]];
        end
    end

    // ---------------- reference model: expected per-cycle activity ----------------
    bit e_busy [NCYC];
    bit e_done [NCYC];
    bit e_pre_cs [NCYC];
    bit e_post_cs [NCYC];
    bit e_cs [NCYC];
    bit e_we [NCYC];
    int e_pre_addr [NCYC];
    int e_post_addr [NCYC];
    int e_addr [NCYC];

    // START is driven in cycle 0; the sweep is an ordered list of steps, each one cycle,
    // where PRE_FETCH and SYN_RD steps wait while STALL was high in the preceding cycle.
    task automatic build_model(input logic [31:0] cnts, input logic [NCYC-1:0] stl,
                               output int done_cyc);
        int t;
        logic [7:0] cnt;
        for (int c = 0; c < NCYC; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_pre_cs[c] = 0; e_post_cs[c] = 0;
            e_cs[c] = 0; e_we[c] = 0; e_pre_addr[c] = 0; e_post_addr[c] = 0; e_addr[c] = 0;
        end
        t = 1;
        for (int p = 0; p < NPRE; p++) begin
            while (t < NCYC - 8 && stl[t-1]) begin e_busy[t] = 1; t++; end
            e_busy[t] = 1; e_pre_cs[t] = 1; e_pre_addr[t] = p; t++;
            e_busy[t] = 1; t++;
            cnt = cnts[p*8 +: 8];
            if (!(SKIP && cnt == 8'd0)) begin
                for (int w = 0; w < WPP; w++) begin
                    while (t < NCYC - 8 && stl[t-1]) begin e_busy[t] = 1; t++; end
                    e_busy[t] = 1; e_cs[t] = 1; e_post_cs[t] = 1;
                    e_addr[t] = p * WPP + w; e_post_addr[t] = w * PAR; t++;
                    e_busy[t] = 1; e_cs[t] = 1; e_we[t] = 1; e_addr[t] = p * WPP + w; t++;
                end
            end
        end
        e_busy[t] = 1; e_done[t] = 1;
        done_cyc = t;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({BUSY, DONE, m.PRE_NEUR_CS, m.POST_NEUR_CS, m.CTRL_SYNARRAY_CS,
                    m.CTRL_SYNARRAY_WE, m.CTRL_GRAD_ARRAY_CS, m.CTRL_GRAD_ARRAY_WE,
                    m.CTRL_SYNARRAY_ADDR, m.PRE_NEUR_ADDR, m.POST_NEUR_ADDR});
    endfunction

    task automatic check_mem(input string tag);
        for (int w = 0; w < NW; w++) begin
            check($sformatf("%s syn_word%0d", tag, w), 64'(syn_mem[w]), 64'(exp_syn[w]));
            check($sformatf("%s grad_word%0d", tag, w), 64'(grad_mem[w]), 64'(exp_grad[w]));
        end
    endtask

    // One sweep: START in cycle 0, STALL/extra START per cycle, every cycle checked against the model.
    task automatic run_case(input string tag, input logic [31:0] cnts,
                            input logic [NCYC-1:0] stl, input logic [NCYC-1:0] sts,
                            output int obs_done, output int obs_acc);
        int model_done;
        int dcnt;
        logic [63:0] act;
        logic [63:0] exp;
        build_model(cnts, stl, model_done);
        for (int p = 0; p < NPRE; p++) pre_cnt[p] = cnts[p*8 +: 8];
        obs_done = -1;
        obs_acc  = 0;
        dcnt     = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge CLK);
            #1;
            act = 64'({BUSY, DONE, m.PRE_NEUR_CS, m.POST_NEUR_CS, m.CTRL_SYNARRAY_CS,
                       m.CTRL_SYNARRAY_WE, m.CTRL_GRAD_ARRAY_CS, m.CTRL_GRAD_ARRAY_WE,
                       (e_cs[c] ? m.CTRL_SYNARRAY_ADDR : 16'd0),
                       (e_pre_cs[c] ? m.PRE_NEUR_ADDR : 10'd0),
                       (e_post_cs[c] ? m.POST_NEUR_ADDR : 10'd0)});
            exp = 64'({e_busy[c], e_done[c], e_pre_cs[c], e_post_cs[c], e_cs[c], e_we[c],
                       e_cs[c], e_we[c], 16'(e_addr[c]), 10'(e_pre_addr[c]), 10'(e_post_addr[c])});
            check($sformatf("%s cycle%0d", tag, c), act, exp);
            if (DONE) begin
                dcnt++;
                if (obs_done < 0) obs_done = c;
            end
            if (m.CTRL_SYNARRAY_CS) obs_acc++;
            START = (c == 0) || sts[c];
            STALL = stl[c];
        end
        START = 1'b0;
        STALL = 1'b0;
        check($sformatf("%s done_count", tag), 64'(dcnt), 64'd1);
        check($sformatf("%s done_cycle_vs_model", tag), 64'(obs_done), 64'(model_done));
        for (int c = 0; c < NCYC; c++) begin
            if (e_we[c]) begin
                exp_syn[e_addr[c]]  = exp_syn[e_addr[c]] + 8'd1;
                exp_grad[e_addr[c]] = exp_grad[e_addr[c]] + 8'd1;
            end
        end
        check_mem(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] cnts;
        int          stall_from;
        int          stall_len;
        int          st0;
        int          st1;
        int          exp_done;
        int          exp_acc;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [NCYC-1:0] stl;
        logic [NCYC-1:0] sts;
        int od;
        int oa;
        int dcnt;
        int bcnt;
        int md;

        tbl[0] = '{32'h01010101, -1, 0, 0,  0, 25, 16};   // plain sweep
        tbl[1] = '{32'h01010101,  4, 5, 0,  0, 30, 16};   // stall from a SYN_WR cycle
        tbl[2] = '{32'h01010101, -1, 0, 5, 10, 25, 16};   // START while busy
        tbl[3] = '{32'h01010101,  0, 3, 0,  0, 28, 16};   // START with STALL in IDLE
        tbl[4] = '{32'h01000300, -1, 0, 0,  0, SKIP ? 17 : 25, SKIP ? 8 : 16};
        tbl[5] = '{32'h02020202,  2, 2, 0,  0, 27, 16};   // stall at SYN_RD entry
        tbl[6] = '{32'h03030303,  6, 1, 0,  0, 26, 16};   // stall at PRE_FETCH entry
        tbl[7] = '{32'h01010101, 24, 1, 0,  0, 25, 16};   // stall before FIN has no effect
        tbl[8] = '{32'h01010101,  3, 1, 0,  0, 25, 16};   // stall during SYN_RD cannot split the pair
        tbl[9] = '{32'h00000000, -1, 0, 0,  0, SKIP ? 9 : 25, SKIP ? 0 : 16};

        for (int w = 0; w < NW; w++) begin
            syn_mem[w] = 8'd10; grad_mem[w] = 8'd40;
            exp_syn[w] = 8'd10; exp_grad[w] = 8'd40;
        end
        for (int p = 0; p < NPRE; p++) pre_cnt[p] = 8'd1;

        // Reset state
        #1 RSTN = 1'b0;
        #1 check("reset_outputs", all_outputs(), 64'd0);
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;

        // First sweep: every word must read back preload + 1
        run_case("basic", tbl[0].cnts, '0, '0, od, oa);
        check("basic done_cycle", 64'(od), 64'd25);
        check("basic syn_word0_is_11", 64'(syn_mem[0]), 64'd11);

        for (int i = 1; i < 10; i++) begin
            stl = '0;
            sts = '0;
            for (int c = 0; c < NCYC; c++)
                stl[c] = (c >= tbl[i].stall_from) && (c < tbl[i].stall_from + tbl[i].stall_len);
            if (tbl[i].st0 > 0) sts[tbl[i].st0] = 1'b1;
            if (tbl[i].st1 > 0) sts[tbl[i].st1] = 1'b1;
            run_case($sformatf("vec%0d", i), tbl[i].cnts, stl, sts, od, oa);
            check($sformatf("vec%0d done_cycle", i), 64'(od), 64'(tbl[i].exp_done));
            check($sformatf("vec%0d access_count", i), 64'(oa), 64'(tbl[i].exp_acc));
        end

        // Reset in cycle 12 of a sweep: outputs drop at once, no DONE, earlier writes persist
        build_model(32'h01010101, '0, md);
        for (int c = 0; c < 12; c++) begin
            if (e_we[c]) begin
                exp_syn[e_addr[c]]  = exp_syn[e_addr[c]] + 8'd1;
                exp_grad[e_addr[c]] = exp_grad[e_addr[c]] + 8'd1;
            end
        end
        for (int p = 0; p < NPRE; p++) pre_cnt[p] = 8'd1;
        for (int c = 0; c <= 12; c++) begin
            @(posedge CLK);
            #1;
            START = (c == 0);
        end
        #1 RSTN = 1'b0;
        #1 check("midreset_outputs", all_outputs(), 64'd0);
        dcnt = 0;
        bcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK);
            #1;
            if (c == 2) RSTN = 1'b1;
            if (DONE) dcnt++;
            if (BUSY) bcnt++;
        end
        check("midreset no_done", 64'(dcnt), 64'd0);
        check("midreset no_busy", 64'(bcnt), 64'd0);
        run_case("after_reset", 32'h01010101, '0, '0, od, oa);
        check("after_reset done_cycle", 64'(od), 64'd25);

        // Randomised sweeps against the model
        for (int r = 0; r < 6; r++) begin
            logic [31:0] cnts;
            stl = '0;
            sts = '0;
            for (int p = 0; p < NPRE; p++) cnts[p*8 +: 8] = 8'($urandom_range(0, 3));
            for (int c = 0; c <= 40; c++) stl[c] = ($urandom_range(0, 3) == 0);
            for (int c = 1; c <= 8; c++)  sts[c] = ($urandom_range(0, 3) == 0);
            run_case($sformatf("rand%0d", r), cnts, stl, sts, od, oa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
